// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box tracker and its coordinate counter.
package bbox_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned PIX_W   = 24;
  localparam int unsigned STATE_W = 2;

  localparam logic [COORD_W-1:0] INVALID_COORD = 16'hFFFF;

  // RGB888 field slices: {R, G, B}
  localparam int unsigned R_HI = 23;
  localparam int unsigned R_LO = 16;
  localparam int unsigned G_HI = 15;
  localparam int unsigned G_LO = 8;
  localparam int unsigned B_HI = 7;
  localparam int unsigned B_LO = 0;

  // Tracker FSM states
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCUM   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PUBLISH = 2'd2;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } bbox_t;

  // Empty accumulator: any real coordinate replaces both min and max
  localparam bbox_t BBOX_EMPTY = '{x_min: INVALID_COORD, x_max: COORD_W'(0),
                                   y_min: INVALID_COORD, y_max: COORD_W'(0)};

  // Published "no box": the overlay never matches these coordinates
  localparam bbox_t BBOX_INVALID = '{x_min: INVALID_COORD, x_max: INVALID_COORD,
                                     y_min: INVALID_COORD, y_max: INVALID_COORD};

  // Mean of two coordinates through a one-bit-wider sum
  function automatic logic [COORD_W-1:0] coord_avg(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W:1];
  endfunction

endpackage

// File: rtl/video_coord_counter.sv
// Active-video x/y counter; shared with the overlay so both see identical coordinates.
// x advances on each qualified pixel, wraps at H_ACTIVE-1 and bumps y; both clear while v_sync is low.
module video_coord_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned COORD_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               h_sync,
  input  logic               v_sync,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  // Next coordinate: the current pixel uses x_q/y_q, the increment lands after it
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!v_sync) begin
      x_d = '0;
      y_d = '0;
    end else if (h_sync) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // Coordinate registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/bbox_tracker.sv
// Per-frame bounding box of pixels inside an RGB colour window; results drive the overlay.
// Optional build macro BBOX_SMOOTH_EN: average each new valid box with the previous valid one.
module bbox_tracker
  import bbox_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [7:0]  R_MIN      = 8'hC0,
  parameter logic [7:0]  G_MAX      = 8'h40,
  parameter logic [7:0]  B_MAX      = 8'h40,
  parameter int unsigned MIN_PIXELS = 16,
  parameter int unsigned CNT_W      = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic [PIX_W-1:0]   pixel_in,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic               bbox_valid,
  output logic [CNT_W-1:0]   pixel_count,
  output logic               frame_done
);

  // Frame geometry must be addressable with 16-bit coordinates
  if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_ACTIVE > 65535 || V_ACTIVE > 65535) begin : g_bad_geometry
    $error("bbox_tracker: H_ACTIVE/V_ACTIVE out of 16-bit coordinate range");
  end

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  logic [COORD_W-1:0] x, y;
  logic               match_c;
  logic               accum_en_c;

  logic [STATE_W-1:0] state_q, state_d;
  logic               armed_q, armed_d;
  bbox_t              acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  bbox_t              box_q, box_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   pcount_q, pcount_d;
  logic               done_q, done_d;

  video_coord_counter #(
    .H_ACTIVE (H_ACTIVE),
    .COORD_W  (COORD_W)
  ) u_coord (
    .clk    (clk),
    .rst    (rst),
    .h_sync (h_sync),
    .v_sync (v_sync),
    .x      (x),
    .y      (y)
  );

  // Colour-window classification of the current qualified pixel
  assign match_c = h_sync && v_sync &&
                   (pixel_in[R_HI:R_LO] >= R_MIN) &&
                   (pixel_in[G_HI:G_LO] <= G_MAX) &&
                   (pixel_in[B_HI:B_LO] <= B_MAX);

  // Next-state, accumulation and publish logic
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | ~v_sync;
    acc_d      = acc_q;
    count_d    = count_q;
    box_d      = box_q;
    valid_d    = valid_q;
    pcount_d   = pcount_q;
    done_d     = 1'b0;
    accum_en_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only start on a frame whose beginning was actually seen
        if (armed_q && v_sync) begin
          state_d    = ST_ACCUM;
          acc_d      = BBOX_EMPTY;
          count_d    = '0;
          accum_en_c = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (!v_sync) begin
          state_d = ST_PUBLISH;
        end else begin
          accum_en_c = 1'b1;
        end
      end
      ST_PUBLISH: begin
        if (count_q >= MIN_CNT) begin
`ifdef BBOX_SMOOTH_EN
          if (valid_q) begin
            box_d.x_min = coord_avg(box_q.x_min, acc_q.x_min);
            box_d.x_max = coord_avg(box_q.x_max, acc_q.x_max);
            box_d.y_min = coord_avg(box_q.y_min, acc_q.y_min);
            box_d.y_max = coord_avg(box_q.y_max, acc_q.y_max);
          end else begin
            box_d = acc_q;
          end
`else
          box_d = acc_q;
`endif
          valid_d = 1'b1;
        end else begin
          box_d   = BBOX_INVALID;
          valid_d = 1'b0;
        end
        pcount_d = count_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Fold a matching pixel into the running box; count saturates
    if (accum_en_c && match_c) begin
      if (x < acc_d.x_min) acc_d.x_min = x;
      if (x > acc_d.x_max) acc_d.x_max = x;
      if (y < acc_d.y_min) acc_d.y_min = y;
      if (y > acc_d.y_max) acc_d.y_max = y;
      if (count_d != '1) count_d = count_d + CNT_W'(1);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      armed_q  <= 1'b0;
      acc_q    <= BBOX_EMPTY;
      count_q  <= '0;
      box_q    <= BBOX_INVALID;
      valid_q  <= 1'b0;
      pcount_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      box_q    <= box_d;
      valid_q  <= valid_d;
      pcount_q <= pcount_d;
      done_q   <= done_d;
    end
  end

  assign bbox_x_min  = box_q.x_min;
  assign bbox_x_max  = box_q.x_max;
  assign bbox_y_min  = box_q.y_min;
  assign bbox_y_max  = box_q.y_max;
  assign bbox_valid  = valid_q;
  assign pixel_count = pcount_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_bbox_tracker.sv
// Self-checking bench for bbox_tracker: directed frame table, multi-cycle corner sequences
// and random frames against a frame-level reference model. Two instances share the stream:
// dut_a (MIN_PIXELS=1, CNT_W=20) and dut_b (MIN_PIXELS=3, CNT_W=4, saturates at 15).
module tb_bbox_tracker;

  localparam int H = 8;
  localparam int V = 6;
  localparam int CMAX_A = (1 << 20) - 1;
  localparam int CMAX_B = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_sync;
  logic        v_sync;
  logic [23:0] pixel_in;

  logic [15:0] x_min_a, x_max_a, y_min_a, y_max_a;
  logic        valid_a, done_a;
  logic [19:0] count_a;
  logic [15:0] x_min_b, x_max_b, y_min_b, y_max_b;
  logic        valid_b, done_b;
  logic [3:0]  count_b;

  bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(1)) dut_a (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .pixel_in(pixel_in),
    .bbox_x_min(x_min_a), .bbox_x_max(x_max_a), .bbox_y_min(y_min_a), .bbox_y_max(y_max_a),
    .bbox_valid(valid_a), .pixel_count(count_a), .frame_done(done_a));

  bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .pixel_in(pixel_in),
    .bbox_x_min(x_min_b), .bbox_x_max(x_max_b), .bbox_y_min(y_min_b), .bbox_y_max(y_max_b),
    .bbox_valid(valid_b), .pixel_count(count_b), .frame_done(done_b));

  always #5 clk = ~clk;

  typedef struct {
    int xmin, xmax, ymin, ymax, cnt;
  } st_t;

  typedef struct {
    int xmin, xmax, ymin, ymax, cnt;
    bit valid;
  } pub_t;

  typedef struct {
    int               n;
    logic [2:0][7:0]  px;
    logic [2:0][7:0]  py;
    logic [2:0][23:0] rgb;
    st_t              exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [23:0] img [0:V][0:H-1];
  pub_t prev_a, prev_b;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one cycle of inputs, then return just after the next rising edge
  task automatic step(input logic h, input logic v, input logic [23:0] p);
    h_sync   = h;
    v_sync   = v;
    pixel_in = p;
    @(posedge clk);
    #1;
  endtask

  function automatic pub_t invalid_pub();
    pub_t r;
    r.xmin = 65535; r.xmax = 65535; r.ymin = 65535; r.ymax = 65535;
    r.cnt = 0; r.valid = 1'b0;
    return r;
  endfunction

  function automatic bit is_match(input logic [23:0] c);
    return (c[23:16] >= 8'hC0) && (c[15:8] <= 8'h40) && (c[7:0] <= 8'h40);
  endfunction

  // Frame-level reference: scan the image for matching pixels
  function automatic st_t model_stats(input int nlines);
    st_t s;
    s.xmin = 65535; s.ymin = 65535; s.xmax = 0; s.ymax = 0; s.cnt = 0;
    for (int yy = 0; yy < nlines; yy++)
      for (int xx = 0; xx < H; xx++)
        if (is_match(img[yy][xx])) begin
          s.cnt++;
          if (xx < s.xmin) s.xmin = xx;
          if (xx > s.xmax) s.xmax = xx;
          if (yy < s.ymin) s.ymin = yy;
          if (yy > s.ymax) s.ymax = yy;
        end
    return s;
  endfunction

  // What a tracker publishes for a frame, given its previous published result
  function automatic pub_t publish(input pub_t prev, input st_t s, input int minpix, input int cmax);
    pub_t r;
    r = invalid_pub();
    r.cnt = (s.cnt > cmax) ? cmax : s.cnt;
    if (r.cnt >= minpix) begin
      r.valid = 1'b1;
      r.xmin = s.xmin; r.xmax = s.xmax; r.ymin = s.ymin; r.ymax = s.ymax;
`ifdef BBOX_SMOOTH_EN
      if (prev.valid) begin
        r.xmin = (prev.xmin + s.xmin) / 2;
        r.xmax = (prev.xmax + s.xmax) / 2;
        r.ymin = (prev.ymin + s.ymin) / 2;
        r.ymax = (prev.ymax + s.ymax) / 2;
      end
`else
      if (prev.valid && r.cnt < 0) r.valid = 1'b0;
`endif
    end
    return r;
  endfunction

  function automatic vec_t mk(input int n,
                              input int x0, input int y0, input logic [23:0] c0,
                              input int x1, input int y1, input logic [23:0] c1,
                              input int x2, input int y2, input logic [23:0] c2,
                              input int xmin, input int xmax, input int ymin, input int ymax,
                              input int cnt);
    vec_t t;
    t.n = n;
    t.px[0] = 8'(x0); t.py[0] = 8'(y0); t.rgb[0] = c0;
    t.px[1] = 8'(x1); t.py[1] = 8'(y1); t.rgb[1] = c1;
    t.px[2] = 8'(x2); t.py[2] = 8'(y2); t.rgb[2] = c2;
    t.exp.xmin = xmin; t.exp.xmax = xmax; t.exp.ymin = ymin; t.exp.ymax = ymax;
    t.exp.cnt = cnt;
    return t;
  endfunction

  task automatic clear_img();
    for (int yy = 0; yy <= V; yy++)
      for (int xx = 0; xx < H; xx++)
        img[yy][xx] = 24'h000000;
  endtask

  // Raster the image with v_sync high; optional unqualified gap cycles carry a red pixel
  task automatic run_frame(input int nlines, input bit gaps);
    for (int yy = 0; yy < nlines; yy++)
      for (int xx = 0; xx < H; xx++) begin
        if (gaps) begin
          int ng = $urandom_range(0, 2);
          for (int g = 0; g < ng; g++) step(1'b0, 1'b1, 24'hFF0000);
        end
        step(1'b1, 1'b1, img[yy][xx]);
      end
  endtask

  task automatic chk_out(input string tag, input pub_t ea, input pub_t eb);
    chk({tag, " a.x_min"}, 32'(x_min_a), ea.xmin);
    chk({tag, " a.x_max"}, 32'(x_max_a), ea.xmax);
    chk({tag, " a.y_min"}, 32'(y_min_a), ea.ymin);
    chk({tag, " a.y_max"}, 32'(y_max_a), ea.ymax);
    chk({tag, " a.valid"}, 32'(valid_a), 32'(ea.valid));
    chk({tag, " a.count"}, 32'(count_a), ea.cnt);
    chk({tag, " b.x_min"}, 32'(x_min_b), eb.xmin);
    chk({tag, " b.x_max"}, 32'(x_max_b), eb.xmax);
    chk({tag, " b.y_min"}, 32'(y_min_b), eb.ymin);
    chk({tag, " b.y_max"}, 32'(y_max_b), eb.ymax);
    chk({tag, " b.valid"}, 32'(valid_b), 32'(eb.valid));
    chk({tag, " b.count"}, 32'(count_b), eb.cnt);
  endtask

  // Close the frame with three v_sync-low cycles; check latency, pulse width and hold
  task automatic end_frame(input string tag, input st_t s);
    pub_t ea, eb;
    ea = publish(prev_a, s, 1, CMAX_A);
    eb = publish(prev_b, s, 3, CMAX_B);
    step(1'b0, 1'b0, 24'h000000);
    chk({tag, " done_early"}, 32'(done_a), 0);
    chk({tag, " hold.x_min"}, 32'(x_min_a), prev_a.xmin);
    chk({tag, " hold.valid"}, 32'(valid_a), 32'(prev_a.valid));
    chk({tag, " hold.count"}, 32'(count_a), prev_a.cnt);
    step(1'b0, 1'b0, 24'h000000);
    chk({tag, " done_a"}, 32'(done_a), 1);
    chk({tag, " done_b"}, 32'(done_b), 1);
    chk_out(tag, ea, eb);
    step(1'b0, 1'b0, 24'h000000);
    chk({tag, " done_clear"}, 32'(done_a), 0);
    prev_a = ea;
    prev_b = eb;
  endtask

  function automatic logic [23:0] rnd_pix(input int dens);
    int k;
    k = $urandom_range(0, 9);
    if (k < dens * 2)
      return {8'($urandom_range(8'hC0, 8'hFF)), 8'($urandom_range(0, 8'h40)),
              8'($urandom_range(0, 8'h40))};
    case ($urandom_range(0, 4))
      0: return 24'hBF0000;
      1: return 24'hFF4100;
      2: return 24'hFF0041;
      3: return 24'($urandom);
      default: return 24'h000000;
    endcase
  endfunction

  initial begin
    st_t s;

    tbl[0] = mk(2, 2,1,24'hFF0000, 5,3,24'hFF0000, 0,0,0,        2,5,1,3, 2);
    tbl[1] = mk(0, 0,0,0,          0,0,0,          0,0,0,        0,0,0,0, 0);
    tbl[2] = mk(3, 0,0,24'hE01010, 7,5,24'hE01010, 4,2,24'hFF5000, 0,7,0,5, 2);
    tbl[3] = mk(3, 1,1,24'hC04040, 2,2,24'hC04040, 3,3,24'hC04040, 1,3,1,3, 3);
    tbl[4] = mk(3, 6,4,24'hFF0000, 1,1,24'hBF0000, 2,2,24'hC04100, 6,6,4,4, 1);
    tbl[5] = mk(0, 0,0,0,          0,0,0,          0,0,0,        0,0,0,0, 0);
    tbl[6] = mk(2, 2,0,24'hFF0000, 6,4,24'hFF0000, 0,0,0,        2,6,0,4, 2);
    tbl[7] = mk(2, 4,2,24'hFF0000, 6,4,24'hFF0000, 0,0,0,        4,6,2,4, 2);

    // Reset: two cycles low
    rst = 1'b0;
    step(1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b0, 24'h000000);
    prev_a = invalid_pub();
    prev_b = invalid_pub();
    chk_out("reset", prev_a, prev_b);
    chk("reset done", 32'(done_a), 0);
    rst = 1'b1;
    step(1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b0, 24'h000000);

    // Directed frames
    for (int i = 0; i < 8; i++) begin
      clear_img();
      for (int k = 0; k < tbl[i].n; k++) img[tbl[i].py[k]][tbl[i].px[k]] = tbl[i].rgb[k];
      run_frame(V, 1'b0);
      end_frame($sformatf("tbl%0d", i), tbl[i].exp);
    end
`ifdef BBOX_SMOOTH_EN
    chk("smooth x_min", 32'(x_min_a), 3);
    chk("smooth y_min", 32'(y_min_a), 1);
`endif

    // v_sync low for a single cycle between two frames
    clear_img();
    img[1][3] = 24'hFF0000;
    img[4][4] = 24'hFF0000;
    run_frame(V, 1'b0);
    s.xmin = 3; s.xmax = 4; s.ymin = 1; s.ymax = 4; s.cnt = 2;
    begin
      pub_t ea, eb;
      ea = publish(prev_a, s, 1, CMAX_A);
      eb = publish(prev_b, s, 3, CMAX_B);
      step(1'b0, 1'b0, 24'h000000);
      chk("vlow1 done_early", 32'(done_a), 0);
      step(1'b0, 1'b1, 24'h000000);
      chk("vlow1 done", 32'(done_a), 1);
      chk_out("vlow1", ea, eb);
      step(1'b0, 1'b1, 24'h000000);
      chk("vlow1 done_clear", 32'(done_a), 0);
      prev_a = ea;
      prev_b = eb;
    end
    clear_img();
    img[2][1] = 24'hFF0000;
    img[5][5] = 24'hFF0000;
    run_frame(V, 1'b0);
    end_frame("vlow1 next", model_stats(V));

    // Reset in the middle of a frame, released with v_sync still high
    for (int xx = 0; xx < 4; xx++) step(1'b1, 1'b1, (xx == 1) ? 24'hFF0000 : 24'h000000);
    rst = 1'b0;
    step(1'b1, 1'b1, 24'hFF0000);
    step(1'b1, 1'b1, 24'hFF0000);
    rst = 1'b1;
    prev_a = invalid_pub();
    prev_b = invalid_pub();
    chk_out("midreset", prev_a, prev_b);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 24'hFF0000);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 24'h000000);
      chk($sformatf("partial no_done%0d", k), 32'(done_a), 0);
    end
    chk("partial valid", 32'(valid_a), 0);
    clear_img();
    img[4][3] = 24'hFF0000;
    run_frame(V, 1'b0);
    s.xmin = 3; s.xmax = 3; s.ymin = 4; s.ymax = 4; s.cnt = 1;
    end_frame("after_reset", s);

    // Random frames against the model
    for (int f = 0; f < 25; f++) begin
      int dens, nl;
      dens = $urandom_range(0, 4);
      nl   = ($urandom_range(0, 9) == 0) ? V + 1 : V;
      clear_img();
      for (int yy = 0; yy < nl; yy++)
        for (int xx = 0; xx < H; xx++) img[yy][xx] = rnd_pix(dens);
      run_frame(nl, 1'($urandom_range(0, 1)));
      end_frame($sformatf("rnd%0d", f), model_stats(nl));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
